bus_xact_driver: RTL and testbench
==================================

Name: bus_xact_driver

Overview:
Upstream bus master stage: accepts a transaction request, arbitrates for the bus, then walks the bus through IDLE -> ARBI -> PREAMBLE -> ADDRESS -> DATA. It drives bus_state/bus_valid/bus_addr/bus_data, which the bus monitor samples. The phase encoding is owned by a shared package so that the RTL, the monitor and the e checker stay aligned.

Parameters:
ADDR_W, 16, address width
DATA_W, 32, data beat width
LEN_W, 4, width of req_len (beats minus 1; max 2**LEN_W beats)
PREAMBLE_CYC, 2, cycles spent in PREAMBLE (>=1)
ARB_TIMEOUT, 16, max cycles in ARBI without grant before abort (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  transaction request valid
req_ready  out  1  driver can accept request (high only in IDLE)
req_addr  in  ADDR_W  transaction address
req_len  in  LEN_W  number of data beats minus 1
wr_valid  in  1  write beat available
wr_data  in  DATA_W  write beat
wr_ready  out  1  beat consumed this cycle
arb_req  out  1  bus request to arbiter
arb_gnt  in  1  bus grant
bus_state  out  state_t  current bus phase
bus_valid  out  1  bus_data holds a valid beat
bus_addr  out  ADDR_W  latched address
bus_data  out  DATA_W  current beat
done  out  1  one-cycle pulse, last beat transferred
err  out  1  one-cycle pulse, arbitration timeout

Behaviour:
- Reset (async, rst=1): bus_state=IDLE; bus_valid, arb_req, wr_ready, done, err=0; bus_addr, bus_data=0; counters=0; req_ready=1 after rst deasserts.
- All outputs registered except req_ready (=bus_state==IDLE) and wr_ready (=bus_state==DATA && wr_valid).
- IDLE: on req_valid && req_ready, latch req_addr into bus_addr and req_len into the beat counter; next state ARBI and arb_req=1.
- ARBI: arb_req held at 1. If arb_gnt is seen: -> PREAMBLE, preamble counter loaded with PREAMBLE_CYC-1. Else the wait counter increments; when it reaches ARB_TIMEOUT-1 without grant: -> IDLE, arb_req=0, err pulses 1 cycle. Grant on the timeout cycle wins (no err).
- PREAMBLE: stays exactly PREAMBLE_CYC cycles, then -> ADDRESS.
- ADDRESS: exactly 1 cycle; bus_addr stable, bus_valid=0; -> DATA.
- DATA: each cycle with wr_valid=1 consumes a beat: bus_data<=wr_data, bus_valid=1 next cycle. wr_valid=0 inserts a stall: bus_valid=0 and bus_data holds. After beat req_len+1 is consumed: -> IDLE next cycle, arb_req=0, done pulses in the same cycle that bus_state returns to IDLE, and bus_valid drops to 0 the cycle after the last beat is presented.
- arb_gnt is ignored outside ARBI. Grant deassertion during PREAMBLE, ADDRESS or DATA does not abort the transaction.
- req_len is all-ones: 2**LEN_W beats; the counter must not wrap early.
- A new request is accepted only in IDLE. Back-to-back: a request held high through done is accepted on the first IDLE cycle. Minimum IDLE dwell is 1 cycle.
- rst asserted mid-transaction: immediate return to the reset values. The partial transaction is dropped with no done and no err.
- bus_state is never driven to a value outside the enum.

Decomposition:
- Package bus_pkg: state_t with explicit encoding IDLE=0, ARBI=1, PREAMBLE=2, ADDRESS=3, DATA=4, 3-bit base type. The monitor and the e checker import the same definitions.
- Optional sub-module bus_phase_timer: loadable down-counter with a zero flag, reused for the preamble count and the arbitration timeout. Everything else stays in the top module.

Test Plan:
- Single beat, defaults: req addr=0x1234, len=0, gnt 2 cycles after arb_req, wr_valid held -> states IDLE,ARBI(x2),PREAMBLE(x2),ADDRESS(x1),DATA(x1); bus_data=beat; done pulse; bus_addr=0x1234 throughout.
- Burst with stalls: len=3, wr_valid low on the 2nd DATA cycle -> exactly 4 bus_valid cycles over 5 DATA cycles, data in order, one done.
- Arb timeout: gnt never asserted -> 16 ARBI cycles, err pulse, return to IDLE, no done; a variant with gnt on cycle 16 gives no err.
- Max length: len=4'hF -> 16 beats, no early exit.
- Reset in DATA after beat 2 of 4 -> all outputs at reset values immediately; next request completes normally.
- Back-to-back: req_valid held high for two requests -> second accepted 1 cycle after the first done; encoding check: bus_state values equal 0..4 as defined in bus_pkg.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus phase encoding for the driver, the bus monitor and the e checker.
// Also holds small elaboration-time helpers used by the driver.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARBI     = 3'd1,
        PREAMBLE = 3'd2,
        ADDRESS  = 3'd3,
        DATA     = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable saturating down-counter with a zero flag; load wins over decrement.
// Zero flag is registered-state based (reflects the current count, no extra latency).
module bus_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_xact_driver.sv
// Bus master: IDLE -> ARBI -> PREAMBLE -> ADDRESS -> DATA, all bus outputs registered.
// Requests taken only in IDLE; wr_valid low in DATA stalls the burst without losing a beat.
module bus_xact_driver
    import bus_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 4,
    parameter int PREAMBLE_CYC = 2,
    parameter int ARB_TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              arb_req,
    input  logic              arb_gnt,
    output state_t            bus_state,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              done,
    output logic              err
);

    // One timer serves both the arbitration wait and the preamble; the phases never overlap.
    localparam int TMR_W = $clog2(max_int(ARB_TIMEOUT, PREAMBLE_CYC) + 1);
    localparam logic [TMR_W-1:0] ARB_LOAD = TMR_W'(ARB_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] PRE_LOAD = TMR_W'(PREAMBLE_CYC - 1);

    state_t              state_q, state_d;
    logic                arb_req_q, arb_req_d;
    logic                bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_load_val;
    logic                tmr_dec;
    logic                tmr_zero;

    bus_phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        arb_req_d    = arb_req_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        beat_cnt_d   = beat_cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                bus_valid_d = 1'b0;
                if (req_valid) begin
                    bus_addr_d   = req_addr;
                    beat_cnt_d   = req_len;
                    arb_req_d    = 1'b1;
                    state_d      = ARBI;
                    tmr_load     = 1'b1;
                    tmr_load_val = ARB_LOAD;
                end
            end

            ARBI: begin
                // A grant on the final wait cycle still wins over the timeout.
                if (arb_gnt) begin
                    state_d      = PREAMBLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = PRE_LOAD;
                end else if (tmr_zero) begin
                    state_d   = IDLE;
                    arb_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            PREAMBLE: begin
                if (tmr_zero) begin
                    state_d = ADDRESS;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ADDRESS: begin
                bus_valid_d = 1'b0;
                state_d     = DATA;
            end

            DATA: begin
                if (wr_valid) begin
                    bus_data_d  = wr_data;
                    bus_valid_d = 1'b1;
                    // Counter holds beats remaining minus one, so all-ones gives the full 2**LEN_W.
                    if (beat_cnt_q == '0) begin
                        state_d   = IDLE;
                        arb_req_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end else begin
                    bus_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                arb_req_d   = 1'b0;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            arb_req_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            arb_req_q   <= arb_req_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == DATA) && wr_valid;
    assign bus_state = state_q;
    assign arb_req   = arb_req_q;
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_data  = bus_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_xact_driver.sv
// Directed bench for bus_xact_driver: hand-computed phase sequences, beats and pulses.
module tb_bus_xact_driver;
    import bus_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              arb_req;
    logic              arb_gnt;
    state_t            bus_state;
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic              done;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    bus_xact_driver #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LEN_W        (LEN_W),
        .PREAMBLE_CYC (2),
        .ARB_TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .arb_req   (arb_req),
        .arb_gnt   (arb_gnt),
        .bus_state (bus_state),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        step();
        req_valid = 1'b0;
        chk("issue_arbi", bus_state, 3'd1);
    endtask

    // Called while observing the first ARBI cycle; grant is seen on ARBI cycle n.
    task automatic grant_on(input int n);
        for (int i = 1; i < n; i++) step();
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        chk("gnt_pre", bus_state, 3'd2);
        chk("gnt_no_err", err, 1'b0);
    endtask

    // Called while observing the first PREAMBLE cycle; leaves us on the first DATA cycle.
    task automatic preamble_addr();
        int npre = 1;
        for (int i = 0; i < 8 && bus_state == PREAMBLE; i++) begin
            step();
            if (bus_state == PREAMBLE) npre++;
        end
        chk("pre_cycles", npre, 2);
        chk("addr_phase", bus_state, 3'd3);
        chk("addr_valid", bus_valid, 1'b0);
        step();
        chk("data_entry", bus_state, 3'd4);
    endtask

    // Drives beats base+k, stalling on DATA cycles whose bit is set in stall_mask.
    task automatic data_phase(input logic [31:0] base, input int nbeats,
                              input logic [31:0] stall_mask, input int exp_dcyc,
                              input string tag);
        int  k_in  = 0;
        int  k_out = 0;
        int  c     = 0;
        int  ndone = 0;
        bit  fin   = 0;
        bit  used;
        for (int i = 0; i < 80 && !fin; i++) begin
            if (bus_state == DATA) begin
                wr_valid = (c < 32) ? !stall_mask[c] : 1'b1;
                wr_data  = base + 32'(k_in);
                c++;
            end else begin
                wr_valid = 1'b0;
            end
            used = wr_valid;
            step();
            if (used) k_in++;
            if (bus_valid) begin
                chk({tag, "_beat"}, bus_data, base + 32'(k_out));
                k_out++;
            end
            if (done) begin
                ndone++;
                chk({tag, "_done_idle"}, bus_state, 3'd0);
                chk({tag, "_done_valid"}, bus_valid, 1'b1);
            end
            if (bus_state == IDLE && !bus_valid) fin = 1;
        end
        wr_valid = 1'b0;
        chk({tag, "_finished"}, fin, 1'b1);
        chk({tag, "_nbeats"}, k_out, nbeats);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_dcycles"}, c, exp_dcyc);
        chk({tag, "_hold"}, bus_data, base + 32'(nbeats - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int narbi;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        arb_gnt   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", bus_state, 3'd0);
        chk("rst_valid", bus_valid, 1'b0);
        chk("rst_arbreq", arb_req, 1'b0);
        chk("rst_wrrdy", wr_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_addr", bus_addr, 16'h0);
        chk("rst_data", bus_data, 32'h0);
        rst = 1'b0;
        step();
        chk("rst_rdy", req_ready, 1'b1);

        // Grant outside ARBI has no effect.
        arb_gnt = 1'b1;
        step();
        arb_gnt = 1'b0;
        chk("idle_gnt_state", bus_state, 3'd0);
        chk("idle_gnt_arbreq", arb_req, 1'b0);

        // Single beat, grant on 2nd ARBI cycle.
        issue(16'h1234, 4'h0);
        chk("t1_arbreq", arb_req, 1'b1);
        chk("t1_rdy", req_ready, 1'b0);
        chk("t1_addr", bus_addr, 16'h1234);
        grant_on(2);
        preamble_addr();
        chk("t1_addr_data", bus_addr, 16'h1234);
        data_phase(32'hA5A5_0000, 1, 32'h0, 1, "t1");
        chk("t1_addr_end", bus_addr, 16'h1234);
        chk("t1_arbreq_end", arb_req, 1'b0);

        // Burst of 4 with a stall on the 2nd DATA cycle.
        issue(16'h2000, 4'h3);
        grant_on(1);
        preamble_addr();
        data_phase(32'hB000_0010, 4, 32'h2, 5, "stall");

        // Arbitration timeout: 16 ARBI cycles, err, no done.
        issue(16'h0BAD, 4'h0);
        narbi = 1;
        for (int i = 0; i < 40 && bus_state == ARBI; i++) begin
            step();
            if (bus_state == ARBI) narbi++;
        end
        chk("to_cycles", narbi, 16);
        chk("to_state", bus_state, 3'd0);
        chk("to_err", err, 1'b1);
        chk("to_done", done, 1'b0);
        chk("to_arbreq", arb_req, 1'b0);
        step();
        chk("to_err_pulse", err, 1'b0);

        // Grant on the 16th ARBI cycle wins over the timeout.
        issue(16'h0C0D, 4'h0);
        grant_on(16);
        preamble_addr();
        data_phase(32'hC0DE_0000, 1, 32'h0, 1, "late");

        // Maximum length burst.
        issue(16'hFFFF, 4'hF);
        grant_on(1);
        preamble_addr();
        data_phase(32'hD000_0100, 16, 32'h0, 16, "max");

        // Reset in DATA after beat 2 of 4.
        issue(16'h4444, 4'h3);
        grant_on(1);
        preamble_addr();
        wr_valid = 1'b1;
        wr_data  = 32'hE000_0000;
        step();
        wr_data  = 32'hE000_0001;
        step();
        chk("mr_pre_data", bus_data, 32'hE000_0001);
        rst = 1'b1;
        #1;
        chk("mr_state", bus_state, 3'd0);
        chk("mr_valid", bus_valid, 1'b0);
        chk("mr_arbreq", arb_req, 1'b0);
        chk("mr_wrrdy", wr_ready, 1'b0);
        chk("mr_addr", bus_addr, 16'h0);
        chk("mr_data", bus_data, 32'h0);
        wr_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("mr_done", done, 1'b0);
        chk("mr_err", err, 1'b0);
        chk("mr_rdy", req_ready, 1'b1);
        issue(16'h5555, 4'h1);
        grant_on(3);
        preamble_addr();
        data_phase(32'hF000_0000, 2, 32'h0, 2, "mr_next");

        // Back-to-back: request held through done is accepted on the done cycle.
        req_valid = 1'b1;
        req_addr  = 16'h0AAA;
        req_len   = 4'h0;
        step();
        chk("b2b_arbi", bus_state, 3'd1);
        chk("b2b_rdy", req_ready, 1'b0);
        grant_on(1);
        preamble_addr();
        wr_valid = 1'b1;
        wr_data  = 32'h1111_2222;
        step();
        wr_valid = 1'b0;
        chk("b2b_done", done, 1'b1);
        chk("b2b_idle", bus_state, 3'd0);
        chk("b2b_rdy_idle", req_ready, 1'b1);
        chk("b2b_beat", bus_data, 32'h1111_2222);
        req_addr = 16'h0BBB;
        req_len  = 4'h1;
        step();
        req_valid = 1'b0;
        chk("b2b_second_arbi", bus_state, 3'd1);
        chk("b2b_second_addr", bus_addr, 16'h0BBB);
        chk("b2b_done_pulse", done, 1'b0);
        chk("b2b_valid_drop", bus_valid, 1'b0);
        grant_on(2);
        preamble_addr();
        data_phase(32'h3333_0000, 2, 32'h0, 2, "b2b2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
